// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the common data bus: reservation-station tags and the
// tag/data pair broadcast on the CDB.
package cpu_types;

   localparam int CDB_MAX_SRC = 8;
   localparam int CDB_DATA_W  = 32;

   typedef enum logic [2:0] {
      INVALID = 3'd0,
      ALU1    = 3'd1,
      ALU2    = 3'd2,
      BR1     = 3'd3,
      LS1     = 3'd4,
      LS2     = 3'd5,
      MUL1    = 3'd6,
      MUL2    = 3'd7
   } RS_tag_type;

   typedef struct packed {
      RS_tag_type            tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_t;

   localparam cdb_t CDB_IDLE = '{tag: INVALID, data: '0};

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result FIFO: power-of-two depth, pointers carry one extra wrap bit
// so full and empty are distinguishable without a counter.
module result_fifo
   import cpu_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic flush,
   input  logic push,
   input  cdb_t din,
   input  logic pop,
   output cdb_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cdb_t         mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge CLK) begin
      if (!RST_N || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_N && !flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises functional-unit results onto the common data bus via per-source
// FIFOs and a round-robin pick. CDB_ARB_STATS_EN adds broadcast/stall counters.
module cdb_arbiter
   import cpu_types::*;
#(
   parameter int N_SRC = 4,
   parameter int DEPTH = 2
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     flush,
   input  logic [N_SRC-1:0]         fu_valid,
   input  cdb_t [N_SRC-1:0]         fu_result,
   output logic [N_SRC-1:0]         fu_ready,
   output cdb_t                     cdb_out,
   output logic [$clog2(N_SRC)-1:0] cdb_src
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [31:0]              bcast_count,
   output logic [31:0]              stall_count
`endif
);

   localparam int SW = $clog2(N_SRC);

   logic [N_SRC-1:0] full;
   logic [N_SRC-1:0] empty;
   logic [N_SRC-1:0] push;
   logic [N_SRC-1:0] pop;
   cdb_t             head [N_SRC];
   logic [SW-1:0]    rr_ptr;
   logic [SW-1:0]    win;
   logic             win_vld;
   logic [SW-1:0]    rr_next;

   // Returns {found, index} of the first set bit at or after start, wrapping mod N_SRC.
   function automatic logic [SW:0] rr_pick(input logic [N_SRC-1:0] req, input logic [SW-1:0] start);
      logic [SW:0]   res;
      logic [SW-1:0] idx;
      res = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         idx = SW'((32'(start) + k) % N_SRC);
         if (!res[SW] && req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      {win_vld, win} = rr_pick(~empty, rr_ptr);
      rr_next        = (win == SW'(N_SRC - 1)) ? '0 : win + SW'(1);
   end

   assign fu_ready = ~full;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      // INVALID-tagged results complete the handshake but are never stored.
      assign push[g] = fu_valid[g] && !full[g] && (fu_result[g].tag != INVALID);
      assign pop[g]  = win_vld && (win == SW'(g));

      result_fifo #(.DEPTH(DEPTH)) u_fifo (
         .CLK   (CLK),
         .RST_N (RST_N),
         .flush (flush),
         .push  (push[g]),
         .din   (fu_result[g]),
         .pop   (pop[g]),
         .dout  (head[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RST_N || flush) begin
         cdb_out <= CDB_IDLE;
         cdb_src <= '0;
         rr_ptr  <= '0;
      end else if (win_vld) begin
         cdb_out <= head[win];
         cdb_src <= win;
         rr_ptr  <= rr_next;
      end else begin
         cdb_out <= CDB_IDLE;
         cdb_src <= '0;
      end
   end

`ifdef CDB_ARB_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         bcast_count <= '0;
         stall_count <= '0;
      end else begin
         if (!flush && win_vld && (bcast_count != '1)) bcast_count <= bcast_count + 32'd1;
         if (|(fu_valid & ~fu_ready) && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table plus randomized traffic checked
// against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
   import cpu_types::*;

   localparam int N = 4;
   localparam int D = 2;

   logic         CLK      = 1'b0;
   logic         RST_N    = 1'b0;
   logic         flush    = 1'b0;
   logic [N-1:0] fu_valid = '0;
   cdb_t [N-1:0] fu_result = '0;
   logic [N-1:0] fu_ready;
   cdb_t         cdb_out;
   logic [1:0]   cdb_src;
`ifdef CDB_ARB_STATS_EN
   logic [31:0]  bcast_count;
   logic [31:0]  stall_count;
`endif

   int   total = 0;
   int   bad   = 0;

   cdb_t mq [N][$];
   int   m_rr  = 0;
   cdb_t m_out = CDB_IDLE;
   int   m_src = 0;
   bit   rdy_chk = 0;
   longint m_bc = 0;
   longint m_st = 0;

   typedef struct {
      logic         rst_n;
      logic         fl;
      logic [N-1:0] v;
      RS_tag_type   t [N];
      RS_tag_type   etag;
      int           esrc;
      logic [N-1:0] erdy;
   } vec_t;

   vec_t tbl[$];

   always #5 CLK = ~CLK;

   cdb_arbiter #(.N_SRC(N), .DEPTH(D)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_result (fu_result),
      .fu_ready  (fu_ready),
      .cdb_out   (cdb_out),
      .cdb_src   (cdb_src)
`ifdef CDB_ARB_STATS_EN
      ,
      .bcast_count (bcast_count),
      .stall_count (stall_count)
`endif
   );

   function automatic logic [31:0] mkdata(int i, RS_tag_type t);
      return 32'h1234_0000 + 32'(i) * 32'h100 + 32'(t);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst_n, input logic fl, input logic [N-1:0] v, input RS_tag_type t [N]);
      logic [N-1:0] erdy;
      int           win;
      win = -1;
      @(negedge CLK);
      RST_N    = rst_n;
      flush    = fl;
      fu_valid = v;
      for (int i = 0; i < N; i++) fu_result[i] = '{tag: t[i], data: mkdata(i, t[i])};
      for (int i = 0; i < N; i++) erdy[i] = (mq[i].size() < D);
      if (rdy_chk) chk("fu_ready", 64'(fu_ready), 64'(erdy));
      @(posedge CLK);
      if (!rst_n || fl) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         m_rr  = 0;
         m_out = CDB_IDLE;
         m_src = 0;
      end else begin
         for (int k = 0; k < N; k++)
            if (win < 0 && mq[(m_rr + k) % N].size() > 0) win = (m_rr + k) % N;
         if (win >= 0) begin
            m_out = mq[win].pop_front();
            m_src = win;
            m_rr  = (win + 1) % N;
         end else begin
            m_out = CDB_IDLE;
            m_src = 0;
         end
         for (int i = 0; i < N; i++)
            if (v[i] && erdy[i] && t[i] != INVALID) mq[i].push_back(fu_result[i]);
      end
      if (!rst_n) begin
         m_bc = 0;
         m_st = 0;
      end else begin
         if (!fl && win >= 0) m_bc++;
         if (|(v & ~erdy)) m_st++;
      end
      #1;
      chk("cdb_out", 64'(cdb_out), 64'(m_out));
      chk("cdb_src", 64'(cdb_src), 64'(m_src));
`ifdef CDB_ARB_STATS_EN
      chk("bcast_count", 64'(bcast_count), 64'(m_bc));
      chk("stall_count", 64'(stall_count), 64'(m_st));
`endif
      rdy_chk = 1;
   endtask

   function automatic void add(logic r, logic f, logic [N-1:0] v,
                               RS_tag_type t0, RS_tag_type t1, RS_tag_type t2, RS_tag_type t3,
                               RS_tag_type et, int es, logic [N-1:0] er);
      vec_t x;
      x.rst_n = r; x.fl = f; x.v = v;
      x.t[0] = t0; x.t[1] = t1; x.t[2] = t2; x.t[3] = t3;
      x.etag = et; x.esrc = es; x.erdy = er;
      tbl.push_back(x);
   endfunction

   initial begin
      RS_tag_type none [N];
      for (int i = 0; i < N; i++) none[i] = INVALID;

      // single source
      add(1, 0, 4'b0001, ALU1, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU1, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // simultaneous, from rr_ptr=0
      add(1, 1, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b1111, ALU1, BR1, LS1, MUL1, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU1, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, BR1, 1, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, LS1, 2, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, MUL1, 3, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // fairness between src 0 and src 2
      add(1, 0, 4'b0101, ALU2, INVALID, LS2, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0101, ALU2, INVALID, LS2, INVALID, ALU2, 0, 4'hF);
      add(1, 0, 4'b0101, ALU2, INVALID, LS2, INVALID, LS2, 2, 4'b1011);
      add(1, 0, 4'b0101, ALU2, INVALID, LS2, INVALID, ALU2, 0, 4'b1110);
      add(1, 0, 4'b0101, ALU2, INVALID, LS2, INVALID, LS2, 2, 4'b1011);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU2, 0, 4'b1110);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, LS2, 2, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU2, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // backpressure on src 1
      add(1, 1, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0011, ALU1, BR1, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0011, ALU1, LS1, INVALID, INVALID, ALU1, 0, 4'hF);
      add(1, 0, 4'b0011, ALU1, MUL2, INVALID, INVALID, BR1, 1, 4'b1101);
      add(1, 0, 4'b0011, ALU1, MUL2, INVALID, INVALID, ALU1, 0, 4'b1110);
      add(1, 0, 4'b0001, ALU1, INVALID, INVALID, INVALID, LS1, 1, 4'b1101);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU1, 0, 4'b1110);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, MUL2, 1, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, ALU1, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // flush with queued results and a new handshake
      add(1, 0, 4'b0111, ALU2, BR1, LS2, INVALID, INVALID, 0, 4'hF);
      add(1, 1, 4'b1000, INVALID, INVALID, INVALID, MUL1, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0100, INVALID, INVALID, LS1, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, LS1, 2, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // INVALID tag is consumed but never broadcast
      add(1, 0, 4'b0010, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      // reset mid-stream
      add(1, 0, 4'b1111, ALU1, ALU2, BR1, MUL1, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, MUL1, 3, 4'hF);
      add(0, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0010, INVALID, BR1, INVALID, INVALID, INVALID, 0, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, BR1, 1, 4'hF);
      add(1, 0, 4'b0000, INVALID, INVALID, INVALID, INVALID, INVALID, 0, 4'hF);

      step(1'b0, 1'b0, '0, none);
      step(1'b0, 1'b0, '0, none);

      for (int n = 0; n < tbl.size(); n++) begin
         chk("tbl_ready", 64'(fu_ready), 64'(tbl[n].erdy));
         step(tbl[n].rst_n, tbl[n].fl, tbl[n].v, tbl[n].t);
         chk("tbl_tag", 64'(cdb_out.tag), 64'(tbl[n].etag));
         chk("tbl_src", 64'(cdb_src), 64'(tbl[n].esrc));
      end

      for (int c = 0; c < 3000; c++) begin
         RS_tag_type   rt [N];
         logic [N-1:0] rv;
         rv = N'($urandom);
         for (int i = 0; i < N; i++) rt[i] = RS_tag_type'($urandom_range(0, 7));
         step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 49) == 0), rv, rt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
